// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin sequencer that shares one external 4:1 mux (mux4_1) between
// four requesters A..D. It drives the mux select, captures the selected word
// into an output register, and presents that word downstream on a
// valid/ready handshake. A requester may hold the grant for up to MAX_BURST
// consecutive words while others are waiting. It keeps the grant for as long
// as it is the only requester.
//
// Parameters
//   WIDTH      data width of the mux inputs/output and of out_data
//   MAX_BURST  consecutive words one source may take while others wait (>=1)
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   req[3:0]   request per source (bit0=A .. bit3=D), held until acked
//   ack[3:0]   one-hot, one-cycle pulse: that source's word was captured
//   sel[1:0]   registered select to mux4_1 (00=A, 01=B, 10=C, 11=D)
//   mux_out    output of mux4_1
//   out_data   captured word
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data when out_valid && out_ready
//   busy       high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    output logic [3:0]       ack,
    output logic [1:0]       sel,
    input  logic [WIDTH-1:0] mux_out,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;

    // Wide enough to hold MAX_BURST itself, so the counter can saturate there.
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    logic [1:0]       state;
    logic [1:0]       last_grant;
    logic [CNT_W-1:0] burst_cnt;

    logic [1:0]       pick;
    logic [3:0]       sel_onehot;
    logic             others_pending;
    logic [CNT_W-1:0] burst_next;

    // Scan last+1, last+2, last+3, then last itself. The loop runs from the
    // farthest candidate to the nearest, so the nearest requester wins. The
    // last grant is therefore chosen only when it is the sole requester.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        pick           = rr_pick(req, last_grant);
        sel_onehot     = 4'b0001 << sel;
        others_pending = |(req & ~sel_onehot);
        burst_next     = (burst_cnt == BURST_LIMIT) ? burst_cnt : burst_cnt + CNT_W'(1);
    end

    assign busy = (state != IDLE);

    // NOTE: all state below is updated with non-blocking assignments. Every
    // branch then reads the pre-edge values of sel, burst_cnt and req, no
    // matter in which order the statements appear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 2'b00;
            last_grant <= 2'd3;
            burst_cnt  <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            ack        <= 4'b0000;
        end else begin
            // ack is a single-cycle pulse. Clear it by default and let the
            // GRANT capture override the clear.
            ack <= 4'b0000;

            case (state)
                IDLE: begin
                    if (|req) begin
                        sel        <= pick;
                        last_grant <= pick;
                        burst_cnt  <= '0;
                        state      <= GRANT;
                    end
                end

                GRANT: begin
                    // sel has been stable for a full cycle, so mux_out has settled.
                    if (req[sel]) begin
                        out_data  <= mux_out;
                        out_valid <= 1'b1;
                        ack       <= sel_onehot;
                        state     <= SEND;
                    end else if (|req) begin
                        // The granted source withdrew its request. Re-arbitrate
                        // and spend another cycle in GRANT for the new select.
                        sel        <= pick;
                        last_grant <= pick;
                        burst_cnt  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end

                SEND: begin
                    // out_valid is always high in SEND. Any change on req is
                    // ignored here until the handshake completes.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        burst_cnt <= burst_next;
                        if (req[sel] && (burst_next < BURST_LIMIT || !others_pending)) begin
                            state <= GRANT;
                        end else if (|req) begin
                            sel        <= pick;
                            last_grant <= pick;
                            burst_cnt  <= '0;
                            state      <= GRANT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Bench for mux4_rr_arbiter. Two instances are used:
//   u_dut  MAX_BURST=4, used for the main and corner-case sequences
//   u_rr   MAX_BURST=1, used for the pure round-robin sequence
// Each instance has a behavioural mux4_1 (mux_out = din[sel]). Expected words
// are queued when requests are driven and compared at each output handshake.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    typedef struct {
        logic [3:0] data;
        logic [1:0] src;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic [1:0] sel;
        logic [3:0] ack;
        logic [3:0] data;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] din [4];

    logic [3:0] req,  rr_req;
    logic [3:0] ack,  rr_ack;
    logic [1:0] sel,  rr_sel;
    logic [3:0] mux_out, rr_mux_out;
    logic [3:0] out_data, rr_out_data;
    logic       out_valid, rr_out_valid;
    logic       out_ready, rr_ready;
    logic       busy, rr_busy;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    exp_t rr_q[$];

    assign mux_out    = din[sel];
    assign rr_mux_out = din[rr_sel];

    mux4_rr_arbiter #(.WIDTH(4), .MAX_BURST(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .sel       (sel),
        .mux_out   (mux_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    mux4_rr_arbiter #(.WIDTH(4), .MAX_BURST(1)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (rr_req),
        .ack       (rr_ack),
        .sel       (rr_sel),
        .mux_out   (rr_mux_out),
        .out_data  (rr_out_data),
        .out_valid (rr_out_valid),
        .out_ready (rr_ready),
        .busy      (rr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboards: an ack must name the selected source, and every
    // handshake must match the oldest queued word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ack != 4'b0000) check("ack_onehot", 32'(ack), 32'(4'b0001 << sel));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got word %0h from src %0d, none expected", out_data, sel);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_data", 32'(out_data), 32'(e.data));
                    check("sb_src", 32'(sel), 32'(e.src));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rr_ack != 4'b0000) check("rr_ack_onehot", 32'(rr_ack), 32'(4'b0001 << rr_sel));
            if (rr_out_valid && rr_ready) begin
                if (rr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rr_sb_extra: got word %0h from src %0d, none expected", rr_out_data, rr_sel);
                end else begin
                    exp_t e;
                    e = rr_q.pop_front();
                    check("rr_sb_data", 32'(rr_out_data), 32'(e.data));
                    check("rr_sb_src", 32'(rr_sel), 32'(e.src));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int which, input logic [3:0] data, input logic [1:0] src);
        exp_t e;
        e.data = data;
        e.src  = src;
        if (which == 0) exp_q.push_back(e);
        else            rr_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        rr_req    = 4'b0000;
        out_ready = 1'b1;
        rr_ready  = 1'b1;
        exp_q.delete();
        rr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Wait until a scoreboard queue drains. n returns the posedges waited.
    task automatic wait_drain(input int which, input int budget, output int n);
        n = 0;
        while (((which == 0) ? exp_q.size() : rr_q.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", 32'((which == 0) ? exp_q.size() : rr_q.size()), 32'd0);
        #1;
    endtask

    vec_t vecs [8];
    int   n;

    initial begin
        // Single-request picks from IDLE. Each row starts from the last_grant
        // left by the previous row (reset value 3).
        vecs[0] = '{req: 4'b0100, sel: 2'd2, ack: 4'b0100, data: 4'd3};
        vecs[1] = '{req: 4'b0001, sel: 2'd0, ack: 4'b0001, data: 4'd1};
        vecs[2] = '{req: 4'b1010, sel: 2'd1, ack: 4'b0010, data: 4'd2};
        vecs[3] = '{req: 4'b1001, sel: 2'd3, ack: 4'b1000, data: 4'd4};
        vecs[4] = '{req: 4'b1000, sel: 2'd3, ack: 4'b1000, data: 4'd4};
        vecs[5] = '{req: 4'b1111, sel: 2'd0, ack: 4'b0001, data: 4'd1};
        vecs[6] = '{req: 4'b0010, sel: 2'd1, ack: 4'b0010, data: 4'd2};
        vecs[7] = '{req: 4'b0011, sel: 2'd0, ack: 4'b0001, data: 4'd1};

        din[0] = 4'd1; din[1] = 4'd2; din[2] = 4'd3; din[3] = 4'd4;
        rst_n = 1'b0; req = 4'b0000; rr_req = 4'b0000;
        out_ready = 1'b1; rr_ready = 1'b1;

        // Reset state
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sel",   32'(sel),       32'd0);
        check("rst_ack",   32'(ack),       32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        do_reset();

        // Table-driven picks and latency
        foreach (vecs[i]) begin
            req = vecs[i].req;
            push(0, vecs[i].data, vecs[i].sel);
            @(negedge clk);
            check("tbl_idle_busy", 32'(busy), 32'd0);
            tick();
            @(negedge clk);
            check("tbl_sel",       32'(sel),       32'(vecs[i].sel));
            check("tbl_grant_ack", 32'(ack),       32'd0);
            check("tbl_grant_vld", 32'(out_valid), 32'd0);
            tick();
            req = 4'b0000;
            @(negedge clk);
            check("tbl_ack",  32'(ack),       32'(vecs[i].ack));
            check("tbl_data", 32'(out_data),  32'(vecs[i].data));
            check("tbl_vld",  32'(out_valid), 32'd1);
            tick();
            @(negedge clk);
            check("tbl_end_busy", 32'(busy),      32'd0);
            check("tbl_end_vld",  32'(out_valid), 32'd0);
            check("tbl_end_ack",  32'(ack),       32'd0);
            tick();
        end

        // Round robin, MAX_BURST=1: 1,2,3,4,1,2,3,4 at one word per 2 cycles
        do_reset();
        rr_req = 4'b1111;
        for (int k = 0; k < 8; k++) push(1, 4'(k % 4 + 1), 2'(k % 4));
        wait_drain(1, 60, n);
        check("rr_cycles", 32'(n), 32'd17);
        rr_req = 4'b0000;
        tick();
        @(negedge clk);
        check("rr_idle", 32'(rr_busy), 32'd0);
        tick();

        // Burst limit, MAX_BURST=4: A x4, then B x4
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 4; k++) push(0, 4'd1, 2'd0);
        for (int k = 0; k < 4; k++) push(0, 4'd2, 2'd1);
        wait_drain(0, 60, n);
        check("burst_cycles", 32'(n), 32'd17);
        req = 4'b0000;
        tick();
        @(negedge clk);
        check("burst_idle", 32'(busy), 32'd0);
        tick();

        // Sole requester keeps the grant beyond MAX_BURST
        req = 4'b0001;
        for (int k = 0; k < 6; k++) push(0, 4'd1, 2'd0);
        wait_drain(0, 60, n);
        check("sole_cycles", 32'(n), 32'd13);
        req = 4'b0000;
        tick();
        @(negedge clk);
        check("sole_idle", 32'(busy), 32'd0);
        tick();

        // Backpressure: B captured, held for 5 stalled cycles. Requests change
        // and the mux input changes during the stall; the next grant goes to C.
        do_reset();
        out_ready = 1'b0;
        req = 4'b0010;
        push(0, 4'd2, 2'd1);
        tick();
        tick();
        req    = 4'b0100;
        din[1] = 4'd9;
        @(negedge clk);
        check("bp_first_ack", 32'(ack), 32'b0010);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check("bp_data", 32'(out_data),  32'd2);
            check("bp_sel",  32'(sel),       32'd1);
            check("bp_ack",  32'(ack),       32'd0);
            check("bp_vld",  32'(out_valid), 32'd1);
        end
        tick();
        out_ready = 1'b1;
        din[1]    = 4'd2;
        push(0, 4'd3, 2'd2);
        tick();
        @(negedge clk);
        check("bp_next_sel", 32'(sel), 32'd2);
        check("bp_next_vld", 32'(out_valid), 32'd0);
        tick();
        req = 4'b0000;
        @(negedge clk);
        check("bp_next_ack",  32'(ack),      32'b0100);
        check("bp_next_data", 32'(out_data), 32'd3);
        tick();
        @(negedge clk);
        check("bp_idle", 32'(busy), 32'd0);
        tick();

        // Request withdrawn in GRANT: C drops with D pending, so D is served
        do_reset();
        req = 4'b1100;
        push(0, 4'd4, 2'd3);
        tick();
        req = 4'b1000;
        @(negedge clk);
        check("wd_sel_c", 32'(sel), 32'd2);
        tick();
        @(negedge clk);
        check("wd_sel_d", 32'(sel),       32'd3);
        check("wd_vld",   32'(out_valid), 32'd0);
        check("wd_ack",   32'(ack),       32'd0);
        tick();
        req = 4'b0000;
        @(negedge clk);
        check("wd_ack_d",  32'(ack),      32'b1000);
        check("wd_data_d", 32'(out_data), 32'd4);
        tick();
        @(negedge clk);
        check("wd_idle", 32'(busy), 32'd0);
        tick();

        // Asynchronous reset in the middle of SEND, while ack is still high
        do_reset();
        out_ready = 1'b0;
        req = 4'b0100;
        tick();
        tick();
        #2;
        check("ar_pre_vld", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_vld",  32'(out_valid), 32'd0);
        check("ar_sel",  32'(sel),       32'd0);
        check("ar_ack",  32'(ack),       32'd0);
        check("ar_busy", 32'(busy),      32'd0);
        req = 4'b0000;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("ar_after_busy", 32'(busy), 32'd0);

        check("end_q",    32'(exp_q.size()), 32'd0);
        check("end_rr_q", 32'(rr_q.size()),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
